turbosound_mixer: RTL
=====================

# turbosound_mixer

Stereo audio mixer that sits directly downstream of two ym2203 instances in a TurboSound-FM setup. It consumes each chip's three PSG channels and its FM channel and builds one signed 16-bit left/right sample per sample strobe. Accumulation is time-multiplexed: one source term per clock through a small sequencer, followed by saturation. The output feeds the system audio path (DC filter / codec serializer).

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- CLK  in  1  global clock
- RESET  in  1  synchronous, active-high reset
- CE_SAMPLE  in  1  one-cycle sample strobe; starts a mix
- MODE  in  2  0 = mono, 1 = ABC stereo, 2 = ACB stereo, 3 = treated as mono
- CHIP_EN  in  2  per-chip enable; bit i = 0 forces all of chip i's terms to 0
- A0, B0, C0, A1, B1, C1  in  8 each  PSG channels, unsigned
- FM0, FM1  in  11 each  FM channels, two's-complement signed
- AUDIO_L, AUDIO_R  out  16  signed mixed sample, registered
- READY  out  1  one-cycle pulse when AUDIO_L/R update
- CLIP  out  1  1 if the last produced sample saturated on either side
- OVERRUN  out  1  sticky; set when CE_SAMPLE arrives while busy

## Operation
- States: IDLE, SUM (step counter 0..7), OUT.
- IDLE, CE_SAMPLE=1:
  - Snapshot all source inputs, MODE and CHIP_EN into internal registers.
  - Clear both 19-bit signed accumulators, step=0, go to SUM.
- Once a mix starts, source inputs and MODE are not sampled again; input changes mid-mix do not affect it.
- SUM: each cycle adds one term to L and/or R, then increments step. The cycle with step 7 goes to OUT.
  - Step order: A0, B0, C0, FM0, A1, B1, C1, FM1.
- Term formation:
  - PSG full = {ch, 4'b0}, zero-extended (0..4080).
  - PSG half = {ch, 3'b0}.
  - FM = sign-extended FM << 3 (-8192..8184).
  - A disabled chip contributes 0.
- Routing:
  - Mono: A, B, C full to both sides.
  - ABC: A full to L, C full to R, B half to both.
  - ACB: A full to L, B full to R, C half to both.
  - FM full to both in all modes.
- OUT:
  - AUDIO_L/R = clamp(acc, -32768, 32767).
  - CLIP = either side clamped.
  - READY=1 for this one cycle, then return to IDLE.
- CE_SAMPLE in SUM or OUT is ignored (sample dropped) and sets OVERRUN. OVERRUN is cleared only by RESET.
- The accumulator cannot overflow: worst-case magnitude is under 2^17.

## Timing
- Reset values: AUDIO_L=0, AUDIO_R=0, READY=0, CLIP=0, OVERRUN=0; state IDLE, accumulators 0.
- Latency: with CE_SAMPLE sampled at edge n, AUDIO_L/R, CLIP and READY update at edge n+9.
- READY is high exactly one cycle. Outputs hold between READY pulses.
- Minimum CE_SAMPLE spacing for no drops: 10 cycles. A CE_SAMPLE at edge n+10 is accepted.
- RESET at any point, including mid-SUM, aborts the mix at that edge:
  - All outputs return to their reset values and no READY is produced.
  - RESET has priority over a simultaneous CE_SAMPLE.
- Back-to-back accepted strobes produce READY at n+9 and n+19 for strobes at n and n+10.

## Test plan
- Mono, CHIP_EN=2'b11, A0=B0=C0=255, everything else 0, CE_SAMPLE at n:
  - READY only at n+9, AUDIO_L=AUDIO_R=12240, CLIP=0.
- ABC, A0=255 only:
  - L=4080, R=0.
- ABC, B0=255 only:
  - L=R=2040.
- ACB, C1=128 only:
  - L=R=1024.
- FM0=11'h400 (-1024), all else 0:
  - L=R=-8192.
- Saturation: all PSG inputs 255, FM0=FM1=1023, mono, both chips enabled:
  - L=R=32767, CLIP=1.
  - Repeat with CHIP_EN=2'b01: L=R=20424, CLIP=0.
- Overrun:
  - CE_SAMPLE at n and n+4 gives a single READY at n+9 and OVERRUN=1.
  - A third CE_SAMPLE at n+10 is accepted; OVERRUN stays 1 until RESET.
- Reset mid-mix: RESET at n+5 after a strobe at n:
  - No READY, AUDIO_L/R=0.
  - A fresh strobe afterwards produces a correct result 9 edges later.

Source files
------------

// File: rtl/turbosound_mixer.sv
// Stereo mixer for two ym2203 chips: one source term per clock into 19-bit
// accumulators, then saturation to a signed 16-bit left/right sample.
module turbosound_mixer (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               CE_SAMPLE,
   input  logic [1:0]         MODE,
   input  logic [1:0]         CHIP_EN,
   input  logic [7:0]         A0,
   input  logic [7:0]         B0,
   input  logic [7:0]         C0,
   input  logic [7:0]         A1,
   input  logic [7:0]         B1,
   input  logic [7:0]         C1,
   input  logic [10:0]        FM0,
   input  logic [10:0]        FM1,
   output logic signed [15:0] AUDIO_L,
   output logic signed [15:0] AUDIO_R,
   output logic               READY,
   output logic               CLIP,
   output logic               OVERRUN
);

   // state | meaning
   // IDLE  | waiting for CE_SAMPLE; snapshot taken on acceptance
   // SUM   | adding one term per cycle, step 0..7
   // OUT   | saturate accumulators, pulse READY
   typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

   localparam logic signed [18:0] SAT_MAX = 19'sd32767;
   localparam logic signed [18:0] SAT_MIN = -19'sd32768;

   state_t             state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic signed [18:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [7:0]         psg_q [0:5];
   logic [10:0]        fm_q  [0:1];
   logic [1:0]         mode_q, en_q;
   logic signed [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
   logic               ready_q, ready_d, clip_q, clip_d, ovr_q, ovr_d;
   logic               load;

   logic               chip_sel;
   logic [1:0]         ch_sel;
   logic [7:0]         psg_sel;
   logic [10:0]        fm_sel;
   logic signed [18:0] full_t, half_t, fm_t, term_l, term_r;
   logic               sat_l, sat_r;

   function automatic logic signed [15:0] clamp16(input logic signed [18:0] v);
      if (v > SAT_MAX)      clamp16 = 16'sh7fff;
      else if (v < SAT_MIN) clamp16 = 16'sh8000;
      else                  clamp16 = v[15:0];
   endfunction

   // Step order A0,B0,C0,FM0,A1,B1,C1,FM1 maps to {chip, channel}
   always_comb begin
      chip_sel = step_q[2];
      ch_sel   = step_q[1:0];
      unique case (step_q)
         3'd0:    psg_sel = psg_q[0];
         3'd1:    psg_sel = psg_q[1];
         3'd2:    psg_sel = psg_q[2];
         3'd4:    psg_sel = psg_q[3];
         3'd5:    psg_sel = psg_q[4];
         3'd6:    psg_sel = psg_q[5];
         default: psg_sel = 8'd0;
      endcase
      fm_sel = fm_q[chip_sel];
      full_t = {7'd0, psg_sel, 4'd0};
      half_t = {8'd0, psg_sel, 3'd0};
      fm_t   = {{5{fm_sel[10]}}, fm_sel, 3'd0};
      term_l = '0;
      term_r = '0;
      if (en_q[chip_sel]) begin
         if (ch_sel == 2'd3) begin
            term_l = fm_t;
            term_r = fm_t;
         end else begin
            unique case (mode_q)
               2'd1: begin
                  if (ch_sel == 2'd0) term_l = full_t;
                  if (ch_sel == 2'd1) begin term_l = half_t; term_r = half_t; end
                  if (ch_sel == 2'd2) term_r = full_t;
               end
               2'd2: begin
                  if (ch_sel == 2'd0) term_l = full_t;
                  if (ch_sel == 2'd1) term_r = full_t;
                  if (ch_sel == 2'd2) begin term_l = half_t; term_r = half_t; end
               end
               default: begin
                  term_l = full_t;
                  term_r = full_t;
               end
            endcase
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      acc_l_d   = acc_l_q;
      acc_r_d   = acc_r_q;
      audio_l_d = audio_l_q;
      audio_r_d = audio_r_q;
      clip_d    = clip_q;
      ready_d   = 1'b0;
      ovr_d     = ovr_q;
      load      = 1'b0;
      sat_l     = (acc_l_q > SAT_MAX) || (acc_l_q < SAT_MIN);
      sat_r     = (acc_r_q > SAT_MAX) || (acc_r_q < SAT_MIN);
      unique case (state_q)
         IDLE: begin
            if (CE_SAMPLE) begin
               load    = 1'b1;
               acc_l_d = '0;
               acc_r_d = '0;
               step_d  = 3'd0;
               state_d = SUM;
            end
         end
         SUM: begin
            acc_l_d = acc_l_q + term_l;
            acc_r_d = acc_r_q + term_r;
            step_d  = step_q + 3'd1;
            if (step_q == 3'd7) state_d = OUT;
         end
         OUT: begin
            audio_l_d = clamp16(acc_l_q);
            audio_r_d = clamp16(acc_r_q);
            clip_d    = sat_l || sat_r;
            ready_d   = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (CE_SAMPLE && (state_q != IDLE)) ovr_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         step_q    <= '0;
         acc_l_q   <= '0;
         acc_r_q   <= '0;
         audio_l_q <= '0;
         audio_r_q <= '0;
         ready_q   <= 1'b0;
         clip_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         acc_l_q   <= acc_l_d;
         acc_r_q   <= acc_r_d;
         audio_l_q <= audio_l_d;
         audio_r_q <= audio_r_d;
         ready_q   <= ready_d;
         clip_q    <= clip_d;
         ovr_q     <= ovr_d;
      end
   end

   // Source snapshot, frozen for the whole mix
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 6; i++) psg_q[i] <= '0;
         fm_q[0] <= '0;
         fm_q[1] <= '0;
         mode_q  <= '0;
         en_q    <= '0;
      end else if (load) begin
         psg_q[0] <= A0;
         psg_q[1] <= B0;
         psg_q[2] <= C0;
         psg_q[3] <= A1;
         psg_q[4] <= B1;
         psg_q[5] <= C1;
         fm_q[0]  <= FM0;
         fm_q[1]  <= FM1;
         mode_q   <= MODE;
         en_q     <= CHIP_EN;
      end
   end

   assign AUDIO_L = audio_l_q;
   assign AUDIO_R = audio_r_q;
   assign READY   = ready_q;
   assign CLIP    = clip_q;
   assign OVERRUN = ovr_q;

endmodule
